// File: rtl/llsc_reservation_ctrl_pkg.sv
// llsc_reservation_ctrl_pkg: shared constants and state encoding for the LL/SC link controller
package llsc_reservation_ctrl_pkg;
  localparam logic RstEnable = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_GRAN_BITS = 2;
  localparam int DEF_TMO_CYC = 1024;
  localparam int DEF_TMO_W = 11;
  typedef enum logic {LLSC_IDLE = 1'b0, LLSC_LINKED = 1'b1} llsc_state_e;
endpackage

// File: rtl/llsc_reservation_ctrl_tmo_counter.sv
// llsc_tmo_counter: link-age counter with clear, enable and terminal-count flag (TMO_CYC=0 never expires)
module llsc_tmo_counter
  import llsc_reservation_ctrl_pkg::*;
#(
  parameter int TMO_CYC = DEF_TMO_CYC,
  parameter int TMO_W = DEF_TMO_W
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam logic [TMO_W-1:0] TC_VAL = TMO_W'((TMO_CYC == 0) ? 0 : TMO_CYC - 1);
  logic [TMO_W-1:0] r_cnt;
  // clear on a new link, otherwise count cycles while the link survives
  always_ff @(posedge clk or posedge rst)
    if (rst == RstEnable) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  assign o_tc = (TMO_CYC != 0) && (r_cnt == TC_VAL);
endmodule

// File: rtl/llsc_reservation_ctrl.sv
// llsc_reservation_ctrl: LL/SC link reservation FSM, SC pass/fail and saturating SC-failure counter
module llsc_reservation_ctrl
  import llsc_reservation_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int GRAN_BITS = DEF_GRAN_BITS,
  parameter int TMO_CYC = DEF_TMO_CYC,
  parameter int TMO_W = DEF_TMO_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ll_req,
  input  logic              sc_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              sc_ok_o,
  output logic              LLbit_o,
  output logic [ADDR_W-1:0] link_addr_o,
  output logic [15:0]       sc_fail_cnt_o
);
  localparam logic [ADDR_W-1:0] GMASK = ~((ADDR_W'(1) << GRAN_BITS) - ADDR_W'(1));
  llsc_state_e r_state, w_next;
  logic [ADDR_W-1:0] r_link_addr;
  logic [15:0] r_fail;
  logic w_linked, w_sc_take, w_ll_take, w_ll_load, w_snoop_hit, w_tc, w_tmo_en;
  assign w_linked = (r_state == LLSC_LINKED);
  assign w_sc_take = sc_req & ~stall;
  assign w_ll_take = ll_req & ~stall;
  assign w_ll_load = w_ll_take & ~flush & ~w_sc_take;
  assign w_snoop_hit = (snoop_we == WriteEnable) & w_linked & ((snoop_addr & GMASK) == r_link_addr);
  assign sc_ok_o = w_sc_take & ~flush & w_linked & ((mem_addr & GMASK) == r_link_addr) & ~w_snoop_hit;
  assign LLbit_o = w_linked;
  assign link_addr_o = r_link_addr;
  assign sc_fail_cnt_o = r_fail;
  llsc_tmo_counter #(.TMO_CYC(TMO_CYC), .TMO_W(TMO_W)) u_tmo (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_ll_load),
    .i_en (w_tmo_en),
    .o_tc (w_tc)
  );
  // next-state in priority order: flush, SC, LL, snoop hit, timeout, keep counting
  always_comb begin
    w_next = r_state;
    w_tmo_en = 1'b0;
    if (flush || w_sc_take) w_next = LLSC_IDLE;
    else if (w_ll_take) w_next = LLSC_LINKED;
    else if (w_snoop_hit || (w_linked && w_tc)) w_next = LLSC_IDLE;
    else w_tmo_en = w_linked;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst == RstEnable) r_state <= LLSC_IDLE;
    else r_state <= w_next;
  // linked address is only rewritten by an accepted LL and holds across clears
  always_ff @(posedge clk or posedge rst)
    if (rst == RstEnable) r_link_addr <= '0;
    else if (w_ll_load) r_link_addr <= mem_addr & GMASK;
  // count retired SCs that fail; killed (flushed) SCs do not count
  always_ff @(posedge clk or posedge rst)
    if (rst == RstEnable) r_fail <= '0;
    else if (w_sc_take && !flush && !sc_ok_o && r_fail != 16'hFFFF) r_fail <= r_fail + 16'd1;
endmodule
